// File: rtl/sdp_sync_fifo.sv
// rtl/sdp_sync_fifo.sv - single-clock FIFO on inferred simple-dual-port RAM, standard or FWFT read port
module sdp_sync_fifo #(
    parameter int C_DATA_WIDTH    = 64,
    parameter int C_DEPTH         = 512,
    parameter int C_FWFT          = 1,
    parameter int C_AFULL_THRESH  = C_DEPTH - 4,
    parameter int C_AEMPTY_THRESH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [C_DATA_WIDTH-1:0]   wr_data,
    input  logic                      rd_en,
    output logic [C_DATA_WIDTH-1:0]   rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(C_DEPTH):0]  count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(C_DEPTH);
    localparam int CW = AW + 1;

    logic [C_DATA_WIDTH-1:0] mem [C_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [C_DATA_WIDTH-1:0] ram_q;
    logic [C_DATA_WIDTH-1:0] out_q;
    logic                    q_valid;
    logic                    out_valid;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    ram_re;
    logic                    out_load;
    logic [CW-1:0]           ram_cnt;
    logic [CW-1:0]           count_next;

    // In FWFT mode ram_q is a prefetch slot in front of the out_q presentation register;
    // count covers RAM plus both stages, ram_cnt is what still sits in the RAM.
    always_comb begin
        wr_acc  = wr_en && !full;
        ram_cnt = count - CW'(q_valid) - CW'(out_valid);
        if (C_FWFT != 0) begin
            rd_acc   = rd_en && out_valid;
            out_load = q_valid && (!out_valid || rd_acc);
            ram_re   = (ram_cnt != '0) && (!q_valid || out_load);
        end else begin
            rd_acc   = rd_en && !empty;
            out_load = 1'b0;
            ram_re   = rd_acc;
        end
        count_next = count;
        if (wr_acc && !rd_acc)
            count_next = count + CW'(1);
        else if (!wr_acc && rd_acc)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !clear)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ram_q        <= '0;
            out_q        <= '0;
            q_valid      <= 1'b0;
            out_valid    <= 1'b0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ram_q        <= '0;
            out_q        <= '0;
            q_valid      <= 1'b0;
            out_valid    <= 1'b0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (ram_re) begin
                rd_ptr <= rd_ptr + 1'b1;
                ram_q  <= mem[rd_ptr];
            end
            if (C_FWFT != 0)
                q_valid <= ram_re || (q_valid && !out_load);
            else
                q_valid <= ram_re;
            if (out_load) begin
                out_q     <= ram_q;
                out_valid <= 1'b1;
            end else if (rd_acc) begin
                out_valid <= 1'b0;
            end
            count        <= count_next;
            full         <= (count_next == CW'(C_DEPTH));
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= CW'(C_AFULL_THRESH));
            almost_empty <= (count_next <= CW'(C_AEMPTY_THRESH));
            if (wr_en && full)
                overflow <= 1'b1;
            if (rd_en && !rd_acc)
                underflow <= 1'b1;
        end
    end

    assign rd_data  = (C_FWFT != 0) ? out_q : ram_q;
    assign rd_valid = (C_FWFT != 0) ? out_valid : q_valid;

endmodule

// File: tb/tb_sdp_sync_fifo.sv
// tb/tb_sdp_sync_fifo.sv - directed bench for sdp_sync_fifo in FWFT and standard read modes
module tb_sdp_sync_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_clear, f_wr_en, f_rd_en;
    logic [63:0] f_wr_data, f_rd_data;
    logic        f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [9:0]  f_count;
    logic        s_clear, s_wr_en, s_rd_en;
    logic [7:0]  s_wr_data, s_rd_data;
    logic        s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [2:0]  s_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       clr;
        logic [2:0] cnt;
        logic       emp, ful, af, ae, rv;
        logic [7:0] rd;
        logic       ovf, udf;
    } vec_t;

    vec_t        tbl [18];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    sdp_sync_fifo dut_f (
        .clk(clk), .rst(rst), .clear(f_clear), .wr_en(f_wr_en), .wr_data(f_wr_data),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    sdp_sync_fifo #(
        .C_DATA_WIDTH(8), .C_DEPTH(4), .C_FWFT(0), .C_AFULL_THRESH(3), .C_AEMPTY_THRESH(1)
    ) dut_s (
        .clk(clk), .rst(rst), .clear(s_clear), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // we, wd, re, clr | cnt, empty, full, af, ae, rv, rd, ovf, udf  (depth 4, afull 3, aempty 1)
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h11, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h22, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h33, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'h44, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h55, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h66, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'h77, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 8'h88, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h88, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 8'h99, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h88, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 8'h5A, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 8'hAB, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAB, 1'b0, 1'b0};

        rst = 1'b0;
        f_clear = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
        s_clear = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        step();

        chk("f_reset_count", f_count, 0);
        chk("f_reset_empty", f_empty, 1);
        chk("f_reset_aempty", f_ae, 1);
        chk("f_reset_full", f_full, 0);
        chk("f_reset_afull", f_af, 0);
        chk("f_reset_rd_valid", f_rd_valid, 0);
        chk("f_reset_ovf", f_ovf, 0);
        chk("f_reset_udf", f_udf, 0);
        chk("s_reset_count", s_count, 0);
        chk("s_reset_empty", s_empty, 1);
        chk("s_reset_rd_valid", s_rd_valid, 0);
        chk("s_reset_rd_data", s_rd_data, 0);

        for (int i = 0; i < 18; i++) begin
            s_wr_en = tbl[i].we; s_wr_data = tbl[i].wd; s_rd_en = tbl[i].re; s_clear = tbl[i].clr;
            step();
            chk($sformatf("s_vec%0d_count", i), s_count, tbl[i].cnt);
            chk($sformatf("s_vec%0d_empty", i), s_empty, tbl[i].emp);
            chk($sformatf("s_vec%0d_full", i), s_full, tbl[i].ful);
            chk($sformatf("s_vec%0d_afull", i), s_af, tbl[i].af);
            chk($sformatf("s_vec%0d_aempty", i), s_ae, tbl[i].ae);
            chk($sformatf("s_vec%0d_rd_valid", i), s_rd_valid, tbl[i].rv);
            chk($sformatf("s_vec%0d_rd_data", i), s_rd_data, tbl[i].rd);
            chk($sformatf("s_vec%0d_ovf", i), s_ovf, tbl[i].ovf);
            chk($sformatf("s_vec%0d_udf", i), s_udf, tbl[i].udf);
        end
        s_wr_en = 1'b0; s_rd_en = 1'b0; s_clear = 1'b0;

        // FWFT latency: write at edge k, head visible after edge k+2
        f_wr_en = 1'b1; f_wr_data = 64'hA5;
        step();
        f_wr_en = 1'b0;
        chk("fwft_lat_k", f_rd_valid, 0);
        step();
        chk("fwft_lat_k1", f_rd_valid, 0);
        step();
        chk("fwft_lat_k2_valid", f_rd_valid, 1);
        chk("fwft_lat_k2_data", f_rd_data, 64'hA5);
        chk("fwft_lat_count", f_count, 1);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        chk("fwft_pop_valid", f_rd_valid, 0);
        chk("fwft_pop_empty", f_empty, 1);
        chk("fwft_pop_count", f_count, 0);

        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        chk("fwft_udf", f_udf, 1);
        chk("fwft_udf_count", f_count, 0);
        chk("fwft_udf_valid", f_rd_valid, 0);
        f_clear = 1'b1;
        step();
        f_clear = 1'b0;
        chk("fwft_udf_clear", f_udf, 0);

        for (int i = 0; i < 512; i++) begin
            f_wr_en = 1'b1; f_wr_data = 64'(i);
            step();
            chk($sformatf("fill_afull_%0d", i + 1), f_af, ((i + 1) >= 508));
        end
        chk("fill_full", f_full, 1);
        chk("fill_count", f_count, 512);
        chk("fill_ovf_before", f_ovf, 0);
        f_wr_data = 64'd999;
        step();
        f_wr_en = 1'b0;
        chk("fill_ovf", f_ovf, 1);
        chk("fill_ovf_count", f_count, 512);

        for (int i = 0; i < 512; i++) begin
            chk($sformatf("drain_valid_%0d", i), f_rd_valid, 1);
            chk($sformatf("drain_data_%0d", i), f_rd_data, 64'(i));
            f_rd_en = 1'b1;
            step();
        end
        f_rd_en = 1'b0;
        chk("drain_empty", f_empty, 1);
        chk("drain_count", f_count, 0);
        chk("drain_valid_end", f_rd_valid, 0);
        f_clear = 1'b1;
        step();
        f_clear = 1'b0;

        for (int i = 0; i < 400; i++) begin
            f_wr_en = 1'b1; f_wr_data = 64'(1000 + i);
            step();
        end
        f_wr_en = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 400; i++) begin
            chk($sformatf("wrap_a_data_%0d", i), f_rd_data, 64'(1000 + i));
            f_rd_en = 1'b1;
            step();
        end
        f_rd_en = 1'b0;
        chk("wrap_a_empty", f_empty, 1);

        // overlap phase crosses the pointer wrap at 512
        for (int i = 0; i < 3; i++) begin
            f_wr_en = 1'b1; f_wr_data = 64'(5000 + i); exp_q.push_back(64'(5000 + i));
            step();
        end
        f_wr_en = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 300; i++) begin
            chk($sformatf("wrap_b_valid_%0d", i), f_rd_valid, 1);
            chk($sformatf("wrap_b_data_%0d", i), f_rd_data, exp_q[0]);
            f_wr_en = 1'b1; f_rd_en = 1'b1; f_wr_data = 64'(6000 + i);
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(64'(6000 + i));
            chk($sformatf("wrap_b_count_%0d", i), f_count, 3);
        end
        f_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap_c_data_%0d", i), f_rd_data, exp_q[0]);
            f_rd_en = 1'b1;
            step();
            void'(exp_q.pop_front());
        end
        f_rd_en = 1'b0;
        chk("wrap_c_empty", f_empty, 1);

        for (int i = 0; i < 100; i++) begin
            f_wr_en = 1'b1; f_wr_data = 64'(i);
            step();
        end
        f_wr_en = 1'b0;
        repeat (2) step();
        chk("areset_pre_count", f_count, 100);
        chk("areset_pre_valid", f_rd_valid, 1);
        f_wr_en = 1'b1; f_wr_data = 64'hDEAD;
        #2 rst = 1'b0;
        #1;
        chk("areset_count", f_count, 0);
        chk("areset_valid", f_rd_valid, 0);
        chk("areset_empty", f_empty, 1);
        f_wr_en = 1'b0;
        step();
        #2 rst = 1'b1;
        step();
        chk("areset_after_count", f_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
